// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with 50% duty for odd and
// even divisors.
//
// A posedge counter runs 0..N-1 and drives pos_q high for the first H = ceil(N/2)
// counts. A negedge copy (neg_q) stretches the low phase by half a source cycle for
// odd N, so clk_o = pos_q & neg_q there. For even N, clk_o = pos_q.
//
// Ports:
//   clk        source clock; both edges are used internally
//   rst        asynchronous reset, active-high
//   en         run request, sampled on posedge clk; only honoured at a period boundary
//   div_load   one-cycle strobe requesting a divisor change to div_i
//   div_i      requested divisor (legal range 2 .. 2**DIV_W-1)
//   div_busy   high while an accepted load waits to be applied
//   div_err    one-cycle pulse when a load is rejected (div_i < 2)
//   div_active divisor currently in use
//   tick_o     one-cycle pulse (posedge domain) at the start of each output period
//   clk_o      divided clock
module clk_div_prog #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_i,
    output logic             div_busy,
    output logic             div_err,
    output logic [DIV_W-1:0] div_active,
    output logic             tick_o,
    output logic             clk_o
);

    localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);
    localparam logic             DefOdd = DefDiv[0];

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             odd_q, odd_d;

    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] half_n;
    logic             wrap;
    logic             apply;

    assign cnt_inc = cnt_q + DIV_W'(1);
    // H = ceil(N/2) without needing an extra bit for N = 2**DIV_W-1.
    assign half_n  = (n_q >> 1) + {{(DIV_W-1){1'b0}}, n_q[0]};
    assign wrap    = (state_q == StRun) && (cnt_q == n_q - DIV_W'(1));
    // A pending divisor lands only where pos_q and neg_q are both low (wrap or idle),
    // so swapping N and the odd/even select there cannot produce a runt pulse.
    assign apply   = pend_q && ((state_q == StIdle) || wrap);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        tick_d     = 1'b0;
        n_d        = n_q;
        odd_d      = odd_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        err_d      = 1'b0;

        if (apply) begin
            n_d    = pend_val_q;
            odd_d  = pend_val_q[0];
            pend_d = 1'b0;
        end

        // A load arriving on the apply edge becomes the next pending value.
        if (div_load) begin
            if (div_i >= DIV_W'(2)) begin
                pend_d     = 1'b1;
                pend_val_d = div_i;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                pos_d = 1'b0;
                if (en) begin
                    state_d = StRun;
                    pos_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            StRun: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (en) begin
                        pos_d  = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        pos_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    pos_d = (cnt_inc < half_n);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                pos_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pos_q      <= 1'b0;
            tick_q     <= 1'b0;
            n_q        <= DefDiv;
            odd_q      <= DefOdd;
            pend_q     <= 1'b0;
            pend_val_q <= DefDiv;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            tick_q     <= tick_d;
            n_q        <= n_d;
            odd_q      <= odd_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            err_q      <= err_d;
        end
    end

    // Half-cycle delayed copy of pos_q; only affects clk_o for odd N.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clk_o      = odd_q ? (pos_q & neg_q) : pos_q;
    assign tick_o     = tick_q;
    assign div_busy   = pend_q;
    assign div_err    = err_q;
    assign div_active = n_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog. clk_o is sampled 1 time unit after every posedge
// and negedge, so each source cycle contributes two bits to the captured waveform.
module tb_clk_div_prog;

    localparam int unsigned DivW = 8;

    logic            clk;
    logic            rst;
    logic            en;
    logic            div_load;
    logic [DivW-1:0] div_i;
    logic            div_busy;
    logic            div_err;
    logic [DivW-1:0] div_active;
    logic            tick_o;
    logic            clk_o;

    int          n_vec = 0;
    int          n_err = 0;
    int          n;
    logic [63:0] wave;
    logic [63:0] ticks;

    clk_div_prog #(
        .DIV_W      (DivW),
        .DEFAULT_DIV(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_load  (div_load),
        .div_i     (div_i),
        .div_busy  (div_busy),
        .div_err   (div_err),
        .div_active(div_active),
        .tick_o    (tick_o),
        .clk_o     (clk_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Strobe div_load for exactly one sampling edge; returns 1 unit after that edge.
    task automatic load_pulse(input logic [DivW-1:0] v);
        @(posedge clk);
        #1;
        div_load = 1'b1;
        div_i    = v;
        @(posedge clk);
        #1;
        div_load = 1'b0;
    endtask

    // Returns 1 unit after the posedge that raised tick_o; bounded.
    task automatic wait_tick(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!tick_o && cycles < 400);
        if (!tick_o) check({tag, "_timeout"}, 64'(tick_o), 64'd1);
    endtask

    // First sample is taken immediately (caller sits just after a period-start edge).
    task automatic sample(input int ncyc, input int drop_at);
        wave  = '0;
        ticks = '0;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            wave  = {wave[62:0], clk_o};
            ticks = {ticks[62:0], tick_o};
            if (i == drop_at) en = 1'b0;
            @(negedge clk);
            #1;
            wave = {wave[62:0], clk_o};
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_i    = '0;

        // Reset state
        #2;
        check("rst_active", 64'(div_active), 64'd3);
        check("rst_clk_o", 64'(clk_o), 64'd0);
        check("rst_tick", 64'(tick_o), 64'd0);
        check("rst_busy", 64'(div_busy), 64'd0);
        check("rst_err", 64'(div_err), 64'd0);

        // 1: default N=3, high 1.5 cycles, tick every third cycle
        #10;
        rst = 1'b0;
        en  = 1'b1;
        wait_tick("t1", n);
        check("t1_start_lat", 64'(n), 64'd1);
        sample(9, -1);
        check("t1_wave", wave, 64'b011100_011100_011100);
        check("t1_ticks", ticks, 64'b100_100_100);

        // 4: illegal loads pulse div_err and change nothing
        load_pulse(8'd1);
        check("t4_err1", 64'(div_err), 64'd1);
        check("t4_busy1", 64'(div_busy), 64'd0);
        check("t4_active1", 64'(div_active), 64'd3);
        cyc();
        check("t4_err_clear", 64'(div_err), 64'd0);
        load_pulse(8'd0);
        check("t4_err0", 64'(div_err), 64'd1);
        check("t4_active0", 64'(div_active), 64'd3);
        check("t4_busy0", 64'(div_busy), 64'd0);
        wait_tick("t4", n);
        sample(6, -1);
        check("t4_wave", wave, 64'b011100_011100);
        check("t4_ticks", ticks, 64'b100_100);

        // 3: load 5 mid-period of N=3; applied on the wrap edge
        wait_tick("t3", n);
        check("t3_align", 64'(n), 64'd1);
        cyc();
        div_load = 1'b1;
        div_i    = 8'd5;
        cyc();
        div_load = 1'b0;
        check("t3_busy_pend", 64'(div_busy), 64'd1);
        check("t3_active_old", 64'(div_active), 64'd3);
        check("t3_no_tick", 64'(tick_o), 64'd0);
        cyc();
        check("t3_active_new", 64'(div_active), 64'd5);
        check("t3_busy_drop", 64'(div_busy), 64'd0);
        check("t3_wrap_tick", 64'(tick_o), 64'd1);
        sample(10, -1);
        check("t3_wave", wave, 64'b0111110000_0111110000);
        check("t3_ticks", ticks, 64'b10000_10000);

        // 2: stop, load 4 while idle, restart with posedge-aligned rising edge
        en = 1'b0;
        cyc();
        check("t2_idle_clk", 64'(clk_o), 64'd0);
        check("t2_idle_tick", 64'(tick_o), 64'd0);
        load_pulse(8'd4);
        check("t2_busy", 64'(div_busy), 64'd1);
        check("t2_active_old", 64'(div_active), 64'd5);
        cyc();
        check("t2_active_new", 64'(div_active), 64'd4);
        check("t2_busy_drop", 64'(div_busy), 64'd0);
        check("t2_idle_clk2", 64'(clk_o), 64'd0);
        en = 1'b1;
        wait_tick("t2", n);
        check("t2_start_lat", 64'(n), 64'd1);
        sample(8, -1);
        check("t2_wave", wave, 64'b11110000_11110000);
        check("t2_ticks", ticks, 64'b1000_1000);

        // 5: N=7, drop en at cnt=2; the period completes, then restart
        load_pulse(8'd7);
        check("t5_busy", 64'(div_busy), 64'd1);
        wait_tick("t5_apply", n);
        check("t5_apply_lat", 64'(n), 64'd3);
        check("t5_active", 64'(div_active), 64'd7);
        sample(10, 2);
        check("t5_wave", wave, 64'b01111111_000000_000000);
        check("t5_ticks", ticks, 64'b1000000_000);
        en = 1'b1;
        wait_tick("t5_restart", n);
        check("t5_restart_lat", 64'(n), 64'd1);
        sample(7, -1);
        check("t5_wave2", wave, 64'b01111111000000);
        check("t5_ticks2", ticks, 64'b1000000);

        // 6: N=255 full period, then async reset in the high phase
        load_pulse(8'd255);
        wait_tick("t6_apply", n);
        check("t6_apply_lat", 64'(n), 64'd6);
        check("t6_active", 64'(div_active), 64'd255);
        wait_tick("t6_period", n);
        check("t6_period", 64'(n), 64'd255);
        cyc();
        cyc();
        cyc();
        check("t6_high", 64'(clk_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_clk", 64'(clk_o), 64'd0);
        check("t6_rst_tick", 64'(tick_o), 64'd0);
        check("t6_rst_active", 64'(div_active), 64'd3);
        check("t6_rst_busy", 64'(div_busy), 64'd0);
        #2;
        rst = 1'b0;
        wait_tick("t6_restart", n);
        check("t6_restart_lat", 64'(n), 64'd1);
        check("t6_active_post", 64'(div_active), 64'd3);
        sample(3, -1);
        check("t6_wave", wave, 64'b011100);
        check("t6_ticks", ticks, 64'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
